// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin shared-register write arbiter.
package arb_pkg;

    localparam int DATA_W    = 32;
    localparam int N_REQ_DEF = 4;
    localparam int ID_W      = $clog2(N_REQ_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Index of the set bit of a one-hot vector (0 when no bit is set).
    function automatic int onehot_to_idx(input logic [7:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first asserted request scanning upward from ptr, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             vld
);

    always_comb begin
        logic found;
        pick  = '0;
        found = 1'b0;
        // Outer loop walks priority order; inner loop keeps every bit select constant.
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == ((int'(ptr) + k) % N))) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared 32-bit register, with bounded locked bursts.
module shared_reg_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [DATA_W*N_REQ-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         q,
    output logic [$clog2(N_REQ)-1:0]  q_owner,
    output logic                      busy
);

    localparam int OW   = $clog2(N_REQ);
    localparam int HC_W = $clog2(MAX_HOLD + 1);

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [HC_W-1:0]     hold_q, hold_d;
    logic [DATA_W-1:0]   data_q;
    logic [OW-1:0]       owner_q;

    logic [OW-1:0]       owner;
    logic [OW-1:0]       nxt_ptr;
    logic [OW-1:0]       pick_ptr;
    logic [N_REQ-1:0]    pick;
    logic                pick_vld;
    logic                xfer;
    logic                keep;
    logic [DATA_W-1:0]   wsel;

    assign owner    = OW'(onehot_to_idx(8'(gnt_q)));
    assign nxt_ptr  = (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);
    // While granted, re-pick starts just past the owner so it ends up lowest priority.
    assign pick_ptr = (state_q == GRANT) ? nxt_ptr : ptr_q;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (OW)
    ) u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .pick (pick),
        .vld  (pick_vld)
    );

    assign xfer = |(gnt_q & req);
    assign keep = (|(gnt_q & req & lock)) && (int'(hold_q) < MAX_HOLD - 1);

    always_comb begin
        wsel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                wsel = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (pick_vld) begin
                    state_d = GRANT;
                    gnt_d   = pick;
                end
            end
            GRANT: begin
                if (keep) begin
                    hold_d = hold_q + HC_W'(1);
                end else begin
                    ptr_d  = nxt_ptr;
                    hold_d = '0;
                    if (pick_vld) begin
                        gnt_d = pick;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            if (xfer) begin
                data_q  <= wsel;
                owner_q <= owner;
            end
        end
    end

    assign gnt     = gnt_q;
    assign q       = data_q;
    assign q_owner = owner_q;
    assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Table-driven bench for shared_reg_arbiter with a write scoreboard and reset corner sequences.
module tb_shared_reg_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   lock;
    logic [127:0] wdata;
    logic [3:0]   gnt;
    logic [31:0]  q;
    logic [1:0]   q_owner;
    logic         busy;

    shared_reg_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_owner (q_owner),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   req;
        logic [3:0]   lock;
        logic [127:0] wd;
        logic [3:0]   egnt;
        logic         ebusy;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  id;
    } wr_t;

    vec_t        tbl[$];
    wr_t         sb[$];
    logic [3:0]  prev_gnt;
    logic [31:0] exp_q;
    logic [1:0]  exp_owner;
    int          n_cmp;
    int          n_bad;

    function automatic vec_t mk(input string n, input logic [3:0] r, input logic [3:0] l,
                                input logic [127:0] w, input logic [3:0] g, input logic b);
        vec_t v;
        v.name = n; v.req = r; v.lock = l; v.wd = w; v.egnt = g; v.ebusy = b;
        return v;
    endfunction

    function automatic logic [127:0] wd4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        wr_t w;
        logic pushed;
        req    = v.req;
        lock   = v.lock;
        wdata  = v.wd;
        pushed = 1'b0;
        // The grant expected last cycle meets this cycle's req: a write lands on the next edge.
        if ((prev_gnt & v.req) != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (prev_gnt[i]) begin
                    w.d  = v.wd[i*32 +: 32];
                    w.id = 2'(i);
                end
            end
            sb.push_back(w);
            pushed = 1'b1;
        end
        tick();
        chk({v.name, ".gnt"}, 32'(gnt), 32'(v.egnt));
        chk({v.name, ".busy"}, 32'(busy), 32'(v.ebusy));
        if (pushed && sb.size() > 0) begin
            w         = sb.pop_front();
            exp_q     = w.d;
            exp_owner = w.id;
        end
        chk({v.name, ".q"}, q, exp_q);
        chk({v.name, ".q_owner"}, 32'(q_owner), 32'(exp_owner));
        prev_gnt = v.egnt;
    endtask

    task automatic expect_idle_zero(input string name);
        chk({name, ".gnt"}, 32'(gnt), 32'h0);
        chk({name, ".q"}, q, 32'h0);
        chk({name, ".q_owner"}, 32'(q_owner), 32'h0);
        chk({name, ".busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [127:0] c;
        n_cmp     = 0;
        n_bad     = 0;
        prev_gnt  = 4'b0000;
        exp_q     = 32'h0;
        exp_owner = 2'd0;
        c         = wd4(32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003);

        // Single write; requester keeps req one cycle past its grant, so it is re-granted once.
        tbl.push_back(mk("single0", 4'b0001, 4'b0000, wd4(32'hDEADBEEF, 0, 0, 0), 4'b0001, 1'b1));
        tbl.push_back(mk("single1", 4'b0001, 4'b0000, wd4(32'hDEADBEEF, 0, 0, 0), 4'b0001, 1'b1));
        tbl.push_back(mk("single2", 4'b0000, 4'b0000, wd4(32'h0BAD_0BAD, 0, 0, 0), 4'b0000, 1'b0));
        tbl.push_back(mk("single3", 4'b0000, 4'b0000, wd4(32'h0BAD_0BAD, 0, 0, 0), 4'b0000, 1'b0));
        // Full contention from ptr=1: strict rotation, one write per cycle.
        tbl.push_back(mk("cont0", 4'b1111, 4'b0000, c, 4'b0010, 1'b1));
        tbl.push_back(mk("cont1", 4'b1111, 4'b0000, c, 4'b0100, 1'b1));
        tbl.push_back(mk("cont2", 4'b1111, 4'b0000, c, 4'b1000, 1'b1));
        tbl.push_back(mk("cont3", 4'b1111, 4'b0000, c, 4'b0001, 1'b1));
        tbl.push_back(mk("cont4", 4'b1111, 4'b0000, c, 4'b0010, 1'b1));
        tbl.push_back(mk("cont5", 4'b0001, 4'b0000, c, 4'b0001, 1'b1));
        tbl.push_back(mk("cont6", 4'b0000, 4'b0000, c, 4'b0000, 1'b0));
        // Locked burst by requester 1 (non-owner lock[2] ignored), capped at MAX_HOLD=4 grants.
        tbl.push_back(mk("lock0", 4'b0110, 4'b0110, wd4(0, 32'hB000_0000, 32'hE000_0000, 0), 4'b0010, 1'b1));
        tbl.push_back(mk("lock1", 4'b0110, 4'b0110, wd4(0, 32'hB000_0001, 32'hE000_0000, 0), 4'b0010, 1'b1));
        tbl.push_back(mk("lock2", 4'b0110, 4'b0110, wd4(0, 32'hB000_0002, 32'hE000_0000, 0), 4'b0010, 1'b1));
        tbl.push_back(mk("lock3", 4'b0110, 4'b0110, wd4(0, 32'hB000_0003, 32'hE000_0000, 0), 4'b0010, 1'b1));
        tbl.push_back(mk("lock4", 4'b0110, 4'b0110, wd4(0, 32'hB000_0004, 32'hE000_0001, 0), 4'b0100, 1'b1));
        tbl.push_back(mk("lock5", 4'b0000, 4'b0000, wd4(0, 32'hB000_0005, 32'hE000_0002, 0), 4'b0000, 1'b0));
        // Early burst end: owner 1 drops req after two writes while requester 3 waits.
        tbl.push_back(mk("early0", 4'b0010, 4'b0010, wd4(0, 32'hC000_0000, 0, 32'hF000_0000), 4'b0010, 1'b1));
        tbl.push_back(mk("early1", 4'b1010, 4'b0010, wd4(0, 32'hC000_0001, 0, 32'hF000_0000), 4'b0010, 1'b1));
        tbl.push_back(mk("early2", 4'b1010, 4'b0010, wd4(0, 32'hC000_0002, 0, 32'hF000_0000), 4'b0010, 1'b1));
        tbl.push_back(mk("early3", 4'b1000, 4'b0010, wd4(0, 32'hC000_0003, 0, 32'hF000_0000), 4'b1000, 1'b1));
        tbl.push_back(mk("early4", 4'b0000, 4'b0000, wd4(0, 32'hC000_0004, 0, 32'hF000_0001), 4'b0000, 1'b0));

        // Reset held across edges with random inputs, then released with no requests.
        rst   = 1'b0;
        req   = 4'($urandom);
        lock  = 4'($urandom);
        wdata = {$urandom, $urandom, $urandom, $urandom};
        tick();
        expect_idle_zero("rst_hold0");
        req   = 4'($urandom);
        wdata = {$urandom, $urandom, $urandom, $urandom};
        tick();
        expect_idle_zero("rst_hold1");
        req   = 4'b0000;
        lock  = 4'($urandom);
        wdata = {$urandom, $urandom, $urandom, $urandom};
        rst   = 1'b1;
        tick();
        expect_idle_zero("rst_rel0");
        tick();
        expect_idle_zero("rst_rel1");

        for (int k = 0; k < tbl.size(); k++) begin
            run_vec(tbl[k]);
        end

        // Asynchronous reset in the middle of requester 2's locked burst.
        run_vec(mk("burst2_0", 4'b0100, 4'b0100, wd4(0, 0, 32'hA000_0000, 0), 4'b0100, 1'b1));
        run_vec(mk("burst2_1", 4'b0100, 4'b0100, wd4(0, 0, 32'hA000_0001, 0), 4'b0100, 1'b1));
        chk("burst2.q_before_rst", q, 32'hA000_0001);
        #2;
        rst = 1'b0;
        #1;
        expect_idle_zero("rst_async");
        sb.delete();
        prev_gnt  = 4'b0000;
        exp_q     = 32'h0;
        exp_owner = 2'd0;
        req       = 4'b1111;
        lock      = 4'b0000;
        #1;
        rst = 1'b1;
        run_vec(mk("post_rst0", 4'b1111, 4'b0000, c, 4'b0001, 1'b1));
        run_vec(mk("post_rst1", 4'b1111, 4'b0000, c, 4'b0010, 1'b1));
        run_vec(mk("post_rst2", 4'b0000, 4'b0000, c, 4'b0000, 1'b0));
        run_vec(mk("post_rst3", 4'b0000, 4'b0000, c, 4'b0000, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
